thread_regfile: RTL

- Per-thread 16 x 8-bit general register file for one SIMD lane of the compute core.
- Sits directly upstream of the lane's ALU wrapper and LSU:
  - supplies registered rs/rt operands, latched in REQUEST;
  - commits the write-back result in UPDATE from ALU output, LSU output or the decoded immediate.
- R13–R15 are read-only special registers: blockIdx, blockDim, threadIdx.

---
 rtl/thread_regfile_pkg.sv | 41 ++++
 rtl/thread_regfile.sv | 132 +++++++++++++
 2 files changed

// File: rtl/thread_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : thread_regfile_pkg
//  Purpose  : Shared encodings for the per-thread register file:
//             - core FSM state codes
//             - write-back source select codes
//             - indices of the read-only special registers
//  Revision : 1.0 - initial release
// ============================================================================
package thread_regfile_pkg;

  // Core FSM state encoding, as driven by the core controller
  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  // Write-back source select; 2'b11 is reserved and never writes
  typedef enum logic [1:0] {
    MUX_ARITH    = 2'b00,
    MUX_MEMORY   = 2'b01,
    MUX_CONST    = 2'b10,
    MUX_RESERVED = 2'b11
  } reg_input_mux_e;

  // Special (read-only) register indices
  localparam logic [3:0] REG_BLOCK_IDX  = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
  localparam logic [3:0] REG_THREAD_IDX = 4'd15;

  // Number of general-purpose, writable registers (R0..R12)
  localparam int c_NUM_GPR = 13;

endpackage : thread_regfile_pkg
`default_nettype wire

// File: rtl/thread_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : thread_regfile
//  Purpose  : Per-thread 16 x DATA_BITS register file for one SIMD lane.
//             R0..R12 general purpose, R13 = blockIdx (tracks block_id),
//             R14 = blockDim (THREADS_PER_BLOCK), R15 = threadIdx (THREAD_ID).
//             Operands are latched in REQUEST, write-back commits in UPDATE.
//  Ports    : clk, reset (sync, active-high), enable (lane active)
//             block_id, core_state, decoded_{rs,rt,rd}_address,
//             decoded_reg_write_enable, decoded_reg_input_mux,
//             decoded_immediate, alu_out, lsu_out  -> inputs
//             rs, rt                                -> registered operands
//             wb_count (only with REGFILE_WB_COUNT_EN) -> committed-write count
//  Options  : `define REGFILE_WB_COUNT_EN adds the saturating wb_count output.
//  Revision : 1.0 - initial release
// ============================================================================
module thread_regfile
  import thread_regfile_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic [3:0]           decoded_rd_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
`ifdef REGFILE_WB_COUNT_EN
  ,
  output logic [15:0]          wb_count
`endif
);

  // R14/R15 never change, so they are constants rather than flops
  localparam logic [DATA_BITS-1:0] c_BLOCK_DIM  = DATA_BITS'(THREADS_PER_BLOCK);
  localparam logic [DATA_BITS-1:0] c_THREAD_IDX = DATA_BITS'(THREAD_ID);

  logic [DATA_BITS-1:0] r_gpr [c_NUM_GPR];
  logic [DATA_BITS-1:0] r_block_idx;
  logic [DATA_BITS-1:0] r_rs;
  logic [DATA_BITS-1:0] r_rt;

  logic [DATA_BITS-1:0] w_rs_val;
  logic [DATA_BITS-1:0] w_rt_val;
  logic [DATA_BITS-1:0] w_wb_data;
  logic                 w_wr_commit;
  logic                 w_is_request;

  assign w_is_request = (core_state == CORE_REQUEST);

  // A commit needs UPDATE, a write instruction, a writable target and a
  // non-reserved source; everything else is silently dropped.
  assign w_wr_commit = (core_state == CORE_UPDATE) &&
                       decoded_reg_write_enable &&
                       (decoded_rd_address < REG_BLOCK_IDX) &&
                       (decoded_reg_input_mux != MUX_RESERVED);

  always_comb begin
    w_wb_data = alu_out;
    case (decoded_reg_input_mux)
      MUX_ARITH:  w_wb_data = alu_out;
      MUX_MEMORY: w_wb_data = lsu_out;
      MUX_CONST:  w_wb_data = decoded_immediate;
      default:    w_wb_data = alu_out;
    endcase
  end

  // Read ports see the pre-update R13, so a same-cycle block_id change is
  // only visible on the next read.
  always_comb begin
    w_rs_val = '0;
    w_rt_val = '0;
    for (int i = 0; i < c_NUM_GPR; i++) begin
      if (decoded_rs_address == 4'(i)) w_rs_val = r_gpr[i];
      if (decoded_rt_address == 4'(i)) w_rt_val = r_gpr[i];
    end
    if (decoded_rs_address == REG_BLOCK_IDX)  w_rs_val = r_block_idx;
    if (decoded_rs_address == REG_BLOCK_DIM)  w_rs_val = c_BLOCK_DIM;
    if (decoded_rs_address == REG_THREAD_IDX) w_rs_val = c_THREAD_IDX;
    if (decoded_rt_address == REG_BLOCK_IDX)  w_rt_val = r_block_idx;
    if (decoded_rt_address == REG_BLOCK_DIM)  w_rt_val = c_BLOCK_DIM;
    if (decoded_rt_address == REG_THREAD_IDX) w_rt_val = c_THREAD_IDX;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_NUM_GPR; i++) r_gpr[i] <= '0;
      r_block_idx <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
    end else if (enable) begin
      r_block_idx <= block_id;
      if (w_is_request) begin
        r_rs <= w_rs_val;
        r_rt <= w_rt_val;
      end
      for (int i = 0; i < c_NUM_GPR; i++) begin
        if (w_wr_commit && (decoded_rd_address == 4'(i))) r_gpr[i] <= w_wb_data;
      end
    end
  end

  assign rs = r_rs;
  assign rt = r_rt;

`ifdef REGFILE_WB_COUNT_EN
  logic [15:0] r_wb_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_count <= '0;
    end else if (enable && w_wr_commit && (r_wb_count != 16'hFFFF)) begin
      r_wb_count <= r_wb_count + 16'd1;
    end
  end

  assign wb_count = r_wb_count;
`endif

endmodule : thread_regfile
`default_nettype wire
